// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: picks a priority among memory/EX stalls,
// mispredict flushes and load-use bubbles, latches early memory responses, and counts events.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             ex_busy,
  input  logic             ex_mispredict,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_uses_rs1,
  input  logic             ifid_uses_rs2,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             imem_hold,
  output logic             dmem_hold,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count
);

  logic imem_done;
  logic dmem_done;
  logic imem_stall;
  logic dmem_stall;
  logic mem_stall;
  logic load_use;
  logic do_flush;
  logic do_bubble;

  assign imem_stall = imem_read & ~imem_resp & ~imem_done;
  assign dmem_stall = dmem_req & ~dmem_resp & ~dmem_done;
  assign mem_stall  = imem_stall | dmem_stall | ex_busy;

  assign load_use = idex_mem_read & (idex_rd != 5'd0) &
                    ((ifid_uses_rs1 & (ifid_rs1 == idex_rd)) |
                     (ifid_uses_rs2 & (ifid_rs2 == idex_rd)));

  assign do_flush  = ~mem_stall & ex_mispredict;
  assign do_bubble = ~mem_stall & ~ex_mispredict & load_use;

  // A frozen pipeline still drains MEMWB once, so WB sees a bubble instead of a repeat.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    memwb_flush = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        memwb_en    = 1'b1;
        memwb_flush = 1'b1;
      end else if (do_flush) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else if (do_bubble) begin
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end
    end
  end

  assign imem_hold = imem_done & ~rst;
  assign dmem_hold = dmem_done & ~rst;

  // Done latches: consuming stage advancing takes priority over a new capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_done <= 1'b0;
      dmem_done <= 1'b0;
    end else begin
      if (ifid_en)
        imem_done <= 1'b0;
      else if (imem_resp && mem_stall)
        imem_done <= 1'b1;
      if (exmem_en)
        dmem_done <= 1'b0;
      else if (dmem_resp && mem_stall)
        dmem_done <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      bubble_count <= '0;
      flush_count  <= '0;
    end else begin
      if (mem_stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (do_bubble && (bubble_count != '1))
        bubble_count <= bubble_count + CNT_W'(1);
      if (do_flush && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl; a narrow counter width makes saturation reachable.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;
  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush, imem_hold, dmem_hold}
  localparam logic [10:0] RUN    = 11'b11010101000;
  localparam logic [10:0] STALL  = 11'b00000001100;
  localparam logic [10:0] FLUSH  = 11'b11111101000;
  localparam logic [10:0] BUBBLE = 11'b00011101000;
  localparam logic [10:0] IH     = 11'b00000000010;
  localparam logic [10:0] DH     = 11'b00000000001;
  localparam logic [10:0] ZERO   = 11'b00000000000;

  logic clk, rst;
  logic imem_read, imem_resp, dmem_req, dmem_resp, ex_busy, ex_mispredict;
  logic idex_mem_read, ifid_uses_rs1, ifid_uses_rs2;
  logic [4:0] idex_rd, ifid_rs1, ifid_rs2;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, exmem_flush, memwb_en, memwb_flush, imem_hold, dmem_hold;
  logic [CNT_W-1:0] stall_cycles, bubble_count, flush_count;

  int vectors = 0;
  int miscompares = 0;
  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .ex_busy(ex_busy), .ex_mispredict(ex_mispredict),
    .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .exmem_flush(exmem_flush),
    .memwb_en(memwb_en), .memwb_flush(memwb_flush),
    .imem_hold(imem_hold), .dmem_hold(dmem_hold),
    .stall_cycles(stall_cycles), .bubble_count(bubble_count), .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] ctrl_vec();
    return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
            memwb_en, memwb_flush, imem_hold, dmem_hold};
  endfunction

  task automatic set_hz(input logic lr, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1, input logic u2);
    idex_mem_read = lr;
    idex_rd       = rd;
    ifid_rs1      = rs1;
    ifid_rs2      = rs2;
    ifid_uses_rs1 = u1;
    ifid_uses_rs2 = u2;
  endtask

  // Drives one cycle just after an edge, samples mid-cycle, returns just after the consuming edge.
  task automatic cyc(input logic ir, input logic iresp, input logic dreq, input logic dresp,
                     input logic busy, input logic mp, input logic [10:0] expected);
    imem_read     = ir;
    imem_resp     = iresp;
    dmem_req      = dreq;
    dmem_resp     = dresp;
    ex_busy       = busy;
    ex_mispredict = mp;
    exp_q.push_back(expected);
    #2;
    obs_q.push_back(ctrl_vec());
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_hz(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    imem_read = 1'b0; imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
    ex_busy = 1'b0; ex_mispredict = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] e, o;
    rst = 1'b1;
    set_hz(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, ZERO);
    rst = 1'b0;
    set_hz(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RUN);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("[TB] FAIL reset ctrl got %b expected %b", o, e); end
    end
    vectors++;
    if ({stall_cycles, bubble_count, flush_count} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset counters got %h/%h/%h expected 0/0/0", stall_cycles, bubble_count, flush_count);
    end
  endtask

  task automatic test_no_hazard();
    logic [10:0] e, o;
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, RUN);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("[TB] FAIL no_hazard ctrl got %b expected %b", o, e); end
    end
    vectors++;
    if ({stall_cycles, bubble_count, flush_count} !== '0) begin
      miscompares++;
      $display("[TB] FAIL no_hazard counters got %h/%h/%h expected 0/0/0", stall_cycles, bubble_count, flush_count);
    end
  endtask

  task automatic test_load_use();
    logic [10:0] e, o;
    do_reset();
    set_hz(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, BUBBLE);
    vectors++;
    if (bubble_count !== 4'd1) begin miscompares++; $display("[TB] FAIL load_use bubble_count got %0d expected 1", bubble_count); end
    set_hz(1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, RUN);
    set_hz(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, RUN);
    set_hz(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, RUN);
    set_hz(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, BUBBLE);
    set_hz(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("[TB] FAIL load_use ctrl got %b expected %b", o, e); end
    end
    vectors++;
    if (bubble_count !== 4'd2) begin miscompares++; $display("[TB] FAIL load_use bubble_total got %0d expected 2", bubble_count); end
  endtask

  task automatic test_dmem_stall();
    logic [10:0] e, o;
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, STALL);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, RUN);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("[TB] FAIL dmem_stall ctrl got %b expected %b", o, e); end
    end
    vectors++;
    if (stall_cycles !== 4'd4) begin miscompares++; $display("[TB] FAIL dmem_stall stall_cycles got %0d expected 4", stall_cycles); end
  endtask

  task automatic test_imem_capture();
    logic [10:0] e, o;
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, STALL);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, STALL | IH);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, STALL | IH);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, RUN | IH);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RUN);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("[TB] FAIL imem_capture ctrl got %b expected %b", o, e); end
    end
    vectors++;
    if (stall_cycles !== 4'd3) begin miscompares++; $display("[TB] FAIL imem_capture stall_cycles got %0d expected 3", stall_cycles); end
  endtask

  task automatic test_mispredict_load_use();
    logic [10:0] e, o;
    do_reset();
    set_hz(1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, FLUSH);
    set_hz(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("[TB] FAIL mispredict_lu ctrl got %b expected %b", o, e); end
    end
    vectors++;
    if (flush_count !== 4'd1 || bubble_count !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL mispredict_lu counts got flush=%0d bubble=%0d expected flush=1 bubble=0", flush_count, bubble_count);
    end
  endtask

  task automatic test_busy_mispredict();
    logic [10:0] e, o;
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, STALL);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, STALL | IH | DH);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, FLUSH | IH | DH);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RUN);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("[TB] FAIL busy_mispredict ctrl got %b expected %b", o, e); end
    end
    vectors++;
    if (flush_count !== 4'd1 || stall_cycles !== 4'd2) begin
      miscompares++;
      $display("[TB] FAIL busy_mispredict counts got flush=%0d stall=%0d expected flush=1 stall=2", flush_count, stall_cycles);
    end
  endtask

  task automatic test_saturation();
    logic [10:0] e, o;
    do_reset();
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FLUSH);
    vectors++;
    if (flush_count !== 4'hF) begin miscompares++; $display("[TB] FAIL saturation reach got %h expected f", flush_count); end
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FLUSH);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("[TB] FAIL saturation ctrl got %b expected %b", o, e); end
    end
    vectors++;
    if (flush_count !== 4'hF) begin miscompares++; $display("[TB] FAIL saturation hold got %h expected f", flush_count); end
  endtask

  task automatic test_reset_mid_stall();
    logic [10:0] e, o;
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, STALL);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ZERO);
    rst = 1'b0;
    vectors++;
    if (stall_cycles !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_mid_stall stall_cycles got %0d expected 0", stall_cycles); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RUN);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("[TB] FAIL reset_mid_stall ctrl got %b expected %b", o, e); end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    do_reset();
    test_reset();
    test_no_hazard();
    test_load_use();
    test_dmem_stall();
    test_imem_capture();
    test_mispredict_load_use();
    test_busy_mispredict();
    test_saturation();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Drives the en/flush pair of IFID, IDEX, EXMEM and MEMWB, plus the PC write enable. Inputs are memory handshakes, load-use hazard information, EX multicycle busy and EX branch mispredict. It latches early memory responses so a response arriving during a stall from another source is not lost. It also keeps saturating performance counters.

Parameters:
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
imem_read  in  1  fetch request outstanding
imem_resp  in  1  fetch response (1-cycle pulse)
dmem_req  in  1  MEM-stage instruction accesses dmem (read or write)
dmem_resp  in  1  dmem response (1-cycle pulse)
ex_busy  in  1  EX multicycle unit not finished
ex_mispredict  in  1  EX resolved branch/jump disagrees with prediction
idex_mem_read  in  1  instruction in EX is a load
idex_rd  in  5  EX destination register
ifid_rs1  in  5  ID source 1
ifid_rs2  in  5  ID source 2
ifid_uses_rs1  in  1  ID reads rs1
ifid_uses_rs2  in  1  ID reads rs2
pc_en  out  1  PC register load
ifid_en, ifid_flush  out  1 each  IFID controls
idex_en, idex_flush  out  1 each  IDEX controls
exmem_en, exmem_flush  out  1 each  EXMEM controls
memwb_en, memwb_flush  out  1 each  MEMWB controls
imem_hold  out  1  fetch stage selects its captured rdata (imem_done)
dmem_hold  out  1  MEM stage selects its captured rdata (dmem_done)
stall_cycles  out  CNT_W  cycles frozen by mem_stall
bubble_count  out  CNT_W  load-use bubbles inserted
flush_count  out  CNT_W  mispredict flushes

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high. While rst is high, all en/flush/hold outputs are 0 and internal state clears on the edge.
- Flush convention: a pipeline register clears only when en=1 and flush=1 in the same cycle.
- State elements:
  - imem_done and dmem_done latches, reset 0.
  - Three counters, reset 0.
- Stall sources (combinational):
  - imem_stall = imem_read & ~imem_resp & ~imem_done
  - dmem_stall = dmem_req & ~dmem_resp & ~dmem_done
  - mem_stall = imem_stall | dmem_stall | ex_busy
- load_use = idex_mem_read & (idex_rd != 0) & ((ifid_uses_rs1 & ifid_rs1 == idex_rd) | (ifid_uses_rs2 & ifid_rs2 == idex_rd)).
- Priority 1, mem_stall:
  - pc_en, ifid_en, idex_en and exmem_en are 0.
  - memwb_en=1 and memwb_flush=1, inserting a WB bubble so the retiring instruction is not written back twice.
  - ex_mispredict and load_use are ignored. Both remain asserted because the registers are frozen.
- Priority 2, ex_mispredict:
  - All en=1.
  - ifid_flush=1 and idex_flush=1; exmem_flush=0 and memwb_flush=0.
  - pc_en=1 and the datapath loads the redirect target.
  - load_use is ignored because the younger instruction is squashed.
- Priority 3, load_use:
  - pc_en=0 and ifid_en=0.
  - idex_en=1 with idex_flush=1, inserting a bubble.
  - exmem_en=1 and memwb_en=1.
  - Exactly one bubble per load: next cycle the load is in MEM, so load_use deasserts.
- Otherwise: all en=1, all flush=0.
- advance = ~mem_stall (ifid_en or pc_en path not frozen).
- imem_done:
  - Set when imem_resp=1 and mem_stall=1 (another source is blocking).
  - Cleared on any cycle with ifid_en=1.
  - If set and clear occur in the same cycle, clear wins.
  - imem_hold = imem_done.
- dmem_done:
  - Set when dmem_resp=1 and mem_stall=1.
  - Cleared when exmem_en=1.
  - dmem_hold = dmem_done.
- Mispredict while imem_done=1: the captured wrong-path word is squashed by ifid_flush and imem_done clears.
- Counters (saturate at all-ones, no wrap):
  - stall_cycles +1 per mem_stall cycle.
  - bubble_count +1 per priority-3 cycle.
  - flush_count +1 per priority-2 cycle.
- Latency: all control outputs are combinational from the current inputs and state, with zero cycles of latency. State updates on the next clk edge.
- Reset mid-stall: the done latches clear. After reset the memory side must reissue its requests.

Test Plan:
- No hazards, imem_resp every cycle for 10 cycles -> all en=1, flush=0, all counters 0.
- Load x5 in EX, ID reads rs2=x5 -> one cycle with pc_en=0, ifid_en=0, idex_en=1, idex_flush=1; bubble_count=1; next cycle all en=1. Repeat with idex_rd=0 -> no bubble.
- dmem_req with resp after 4 cycles -> 4 cycles with pc/ifid/idex/exmem en=0 and memwb_en=memwb_flush=1; stall_cycles=4.
- imem_resp arrives in cycle 1 of a 3-cycle dmem stall -> imem_done=1 and imem_hold=1 for cycles 2-3; both clear on the advance cycle; no extra fetch stall.
- ex_mispredict concurrent with load_use, no stall -> ifid_flush=idex_flush=1, pc_en=1, flush_count=1, bubble_count unchanged. Concurrent with ex_busy for 2 cycles -> no flush until busy drops.
- Force flush_count to all-ones, then another mispredict -> stays all-ones. Assert rst mid-stall -> all outputs 0, latches and counters 0 after the edge.
